slave_regfile: RTL and testbench

- Bus target that sits directly downstream of the master register stage on the shared address/data bus.
- Decodes the master's addr/read/write/valid request against a local bank of NUM_REGS 32-bit registers.
- Applies a programmable wait-state delay, then answers with a one-cycle ready pulse.
- On reads, returns read_data; on writes, commits write_data.

---
 rtl/slave_regfile_pkg.sv | 16 +
 rtl/slave_regfile_reg_array.sv | 32 +++
 rtl/slave_regfile.sv | 144 ++++++++++++++
 tb/tb_slave_regfile.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/slave_regfile_pkg.sv
// Shared types and constants for the slave register-file bus target.
package slave_pkg;

  typedef enum logic [1:0] {
    SL_IDLE,
    SL_WAIT,
    SL_RESP
  } slave_state_t;

  localparam logic [1:0] OP_RD  = 2'd0;
  localparam logic [1:0] OP_WR  = 2'd1;
  localparam logic [1:0] OP_BAD = 2'd2;

  localparam int WORD_BYTES = 4;

endpackage

// File: rtl/slave_regfile_reg_array.sv
// NUM_REGS x DATA_W register bank: synchronous write, combinational read,
// synchronous active-low clear.
module slave_reg_array #(
  parameter int NUM_REGS = 16,
  parameter int DATA_W   = 32
) (
  input  logic                        clk,
  input  logic                        i_clr_n,
  input  logic                        i_we,
  input  logic [$clog2(NUM_REGS)-1:0] i_widx,
  input  logic [DATA_W-1:0]           i_wdata,
  input  logic [$clog2(NUM_REGS)-1:0] i_ridx,
  output logic [DATA_W-1:0]           o_rdata
);

  logic [DATA_W-1:0] r_mem [NUM_REGS];

  // NOTE: the bank must read back zero after reset, so every word is cleared;
  // this keeps it out of RAM macros, which cannot be reset in one cycle.
  always_ff @(posedge clk) begin
    if (!i_clr_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        r_mem[i] <= '0;
      end
    end else if (i_we) begin
      r_mem[i_widx] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_ridx];

endmodule

// File: rtl/slave_regfile.sv
// Bus target: decodes master requests onto a register bank with programmable
// wait states and a one-cycle ready pulse. Define SLAVE_REGFILE_ERR_EN to add the err output.
module slave_regfile
  import slave_pkg::*;
#(
  parameter int                ADDR_W      = 16,
  parameter int                DATA_W      = 32,
  parameter int                NUM_REGS    = 16,
  parameter logic [ADDR_W-1:0] BASE_ADDR   = '0,
  parameter int                WAIT_STATES = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              valid,
  input  logic              read,
  input  logic              write,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] write_data,
  output logic              ready,
  output logic [DATA_W-1:0] read_data
`ifdef SLAVE_REGFILE_ERR_EN
  ,
  output logic              err
`endif
);

  localparam int                IDX_W  = $clog2(NUM_REGS);
  localparam int                BYTE_W = $clog2(WORD_BYTES);
  localparam int                CNT_W  = 4;
  localparam logic [ADDR_W-1:0] LIMIT  = ADDR_W'(NUM_REGS);

  slave_state_t      r_state, w_next;
  logic [CNT_W-1:0]  r_cnt;
  logic [1:0]        r_op;
  logic [IDX_W-1:0]  r_idx;
  logic [DATA_W-1:0] r_wdata;
  logic              r_legal;
  logic              r_ready;
  logic [DATA_W-1:0] r_read_data;
  logic              r_err;

  logic [ADDR_W-1:0] w_off, w_word;
  logic [1:0]        w_in_op;
  logic              w_in_legal;
  logic              w_accept, w_resp, w_commit;
  logic [1:0]        w_cur_op;
  logic [IDX_W-1:0]  w_cur_idx;
  logic [DATA_W-1:0] w_cur_wdata;
  logic              w_cur_legal;
  logic [DATA_W-1:0] w_rdata;

  // Decode of the live bus; only meaningful in the cycle a request is accepted.
  assign w_off      = addr - BASE_ADDR;
  assign w_word     = w_off >> BYTE_W;
  assign w_in_op    = (read && write) ? OP_BAD : (read ? OP_RD : OP_WR);
  assign w_in_legal = (addr >= BASE_ADDR) && (w_off[BYTE_W-1:0] == '0) &&
                      (w_word < LIMIT) && (w_in_op != OP_BAD);

  // With zero wait states the response edge is the acceptance edge, so the
  // live request is used there instead of the not-yet-loaded latches.
  assign w_cur_op    = (r_state == SL_IDLE) ? w_in_op             : r_op;
  assign w_cur_idx   = (r_state == SL_IDLE) ? w_word[IDX_W-1:0]   : r_idx;
  assign w_cur_wdata = (r_state == SL_IDLE) ? write_data          : r_wdata;
  assign w_cur_legal = (r_state == SL_IDLE) ? w_in_legal          : r_legal;

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    w_next   = r_state;
    w_accept = 1'b0;
    unique case (r_state)
      SL_IDLE: begin
        if (valid && (read || write)) begin
          w_accept = 1'b1;
          w_next   = (WAIT_STATES == 0) ? SL_RESP : SL_WAIT;
        end
      end
      SL_WAIT: begin
        if (!valid) begin
          w_next = SL_IDLE;
        end else if (r_cnt == CNT_W'(1)) begin
          w_next = SL_RESP;
        end
      end
      SL_RESP: w_next = SL_IDLE;
      default: w_next = SL_IDLE;
    endcase
  end

  assign w_resp   = (w_next == SL_RESP);
  assign w_commit = w_resp && (w_cur_op == OP_WR) && w_cur_legal;

  slave_reg_array #(
    .NUM_REGS (NUM_REGS),
    .DATA_W   (DATA_W)
  ) u_regs (
    .clk     (clk),
    .i_clr_n (reset),
    .i_we    (w_commit),
    .i_widx  (w_cur_idx),
    .i_wdata (w_cur_wdata),
    .i_ridx  (w_cur_idx),
    .o_rdata (w_rdata)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state     <= SL_IDLE;
      r_cnt       <= '0;
      r_op        <= OP_RD;
      r_idx       <= '0;
      r_wdata     <= '0;
      r_legal     <= 1'b0;
      r_ready     <= 1'b0;
      r_read_data <= '0;
      r_err       <= 1'b0;
    end else begin
      r_state <= w_next;
      r_ready <= w_resp;
      r_err   <= w_resp && !w_cur_legal;
      if (w_accept) begin
        r_op    <= w_in_op;
        r_idx   <= w_word[IDX_W-1:0];
        r_wdata <= write_data;
        r_legal <= w_in_legal;
        r_cnt   <= CNT_W'(WAIT_STATES);
      end else if (r_state == SL_WAIT) begin
        r_cnt <= r_cnt - CNT_W'(1);
      end
      if (w_resp && (w_cur_op == OP_RD)) begin
        r_read_data <= w_cur_legal ? w_rdata : '0;
      end
    end
  end

  assign ready     = r_ready;
  assign read_data = r_read_data;
`ifdef SLAVE_REGFILE_ERR_EN
  assign err = r_err;
`else
  logic w_err_unused;
  assign w_err_unused = r_err;
`endif

endmodule

// File: tb/tb_slave_regfile.sv
// Directed bench for slave_regfile: three instances with WAIT_STATES 0, 1 and 3
// sharing bus inputs, each with its own valid.
module tb_slave_regfile;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [2:0]  v = '0;
  logic        read = 1'b0;
  logic        write = 1'b0;
  logic [15:0] addr = '0;
  logic [31:0] wdata = '0;
  logic [2:0]  rdy;
  logic [31:0] rdat [3];
  logic [2:0]  errs;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  slave_regfile #(.WAIT_STATES(0)) dut0 (
    .clk(clk), .reset(reset), .valid(v[0]), .read(read), .write(write),
    .addr(addr), .write_data(wdata), .ready(rdy[0]), .read_data(rdat[0])
`ifdef SLAVE_REGFILE_ERR_EN
    , .err(errs[0])
`endif
  );

  slave_regfile #(.WAIT_STATES(1)) dut1 (
    .clk(clk), .reset(reset), .valid(v[1]), .read(read), .write(write),
    .addr(addr), .write_data(wdata), .ready(rdy[1]), .read_data(rdat[1])
`ifdef SLAVE_REGFILE_ERR_EN
    , .err(errs[1])
`endif
  );

  slave_regfile #(.WAIT_STATES(3)) dut3 (
    .clk(clk), .reset(reset), .valid(v[2]), .read(read), .write(write),
    .addr(addr), .write_data(wdata), .ready(rdy[2]), .read_data(rdat[2])
`ifdef SLAVE_REGFILE_ERR_EN
    , .err(errs[2])
`endif
  );

`ifndef SLAVE_REGFILE_ERR_EN
  assign errs = '0;
`endif

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Ready is expected 'lat' sampling points after the accepting edge.
  function automatic int lat_of(input int k);
    return (k == 0) ? 1 : ((k == 1) ? 2 : 4);
  endfunction

  task automatic run(input int k, input logic rd, input logic wr, input logic [15:0] a,
                     input logic [31:0] d, input logic chk_rd, input logic [31:0] exp_rd,
                     input logic exp_err, input string tag);
    int lat;
    lat = lat_of(k);
    @(negedge clk);
    v[k] = 1'b1; read = rd; write = wr; addr = a; wdata = d;
    for (int i = 1; i <= lat; i++) begin
      @(negedge clk);
      check({tag, "_rdy"}, {31'b0, rdy[k]}, {31'b0, i == lat});
      if (i == lat) begin
        if (chk_rd) check({tag, "_rdata"}, rdat[k], exp_rd);
`ifdef SLAVE_REGFILE_ERR_EN
        check({tag, "_err"}, {31'b0, errs[k]}, {31'b0, exp_err});
`endif
        v[k] = 1'b0; read = 1'b0; write = 1'b0;
      end
    end
    @(negedge clk);
    check({tag, "_rdy_drop"}, {31'b0, rdy[k]}, 32'd0);
    check({tag, "_err_drop"}, {31'b0, errs[k]}, 32'd0);
  endtask

  initial begin
    // Reset
    repeat (2) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      check("rst_rdy", {31'b0, rdy[k]}, 32'd0);
      check("rst_rdata", rdat[k], 32'd0);
      check("rst_err", {31'b0, errs[k]}, 32'd0);
    end
    reset = 1'b1;

    // 1-2: write then read with hold
    run(1, 1'b0, 1'b1, 16'h0010, 32'hDEADBEEF, 1'b0, 32'd0, 1'b0, "wr10");
    run(1, 1'b1, 1'b0, 16'h0010, 32'd0, 1'b1, 32'hDEADBEEF, 1'b0, "rd10");
    repeat (3) @(negedge clk);
    check("rd10_hold", rdat[1], 32'hDEADBEEF);

    // 3: out-of-range and misaligned writes
    run(1, 1'b0, 1'b1, 16'h0040, 32'h5555AAAA, 1'b0, 32'd0, 1'b1, "wr40");
    check("hold_after_wr", rdat[1], 32'hDEADBEEF);
    run(1, 1'b0, 1'b1, 16'h0013, 32'h0000BAD0, 1'b0, 32'd0, 1'b1, "wr13");
    run(1, 1'b1, 1'b0, 16'h0010, 32'd0, 1'b1, 32'hDEADBEEF, 1'b0, "rd10b");
    run(1, 1'b1, 1'b0, 16'h0000, 32'd0, 1'b1, 32'd0, 1'b0, "rd00");
    run(1, 1'b1, 1'b0, 16'h0010, 32'd0, 1'b1, 32'hDEADBEEF, 1'b0, "rd10c");
    run(1, 1'b1, 1'b0, 16'h0040, 32'd0, 1'b1, 32'd0, 1'b1, "rd40");

    // 4: read&write together, then abort during wait
    run(1, 1'b0, 1'b1, 16'h0000, 32'hA5A50001, 1'b0, 32'd0, 1'b0, "wr00");
    run(1, 1'b1, 1'b1, 16'h0000, 32'hFFFFFFFF, 1'b0, 32'd0, 1'b1, "rdwr00");
    run(1, 1'b1, 1'b0, 16'h0000, 32'd0, 1'b1, 32'hA5A50001, 1'b0, "rd00b");

    @(negedge clk);
    v[2] = 1'b1; write = 1'b1; addr = 16'h0004; wdata = 32'h00000077;
    @(negedge clk);
    v[2] = 1'b0; write = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("abort_rdy", {31'b0, rdy[2]}, 32'd0);
    end
    run(2, 1'b1, 1'b0, 16'h0004, 32'd0, 1'b1, 32'd0, 1'b0, "abort_rd04");

    // 5: reset during wait
    @(negedge clk);
    v[1] = 1'b1; write = 1'b1; addr = 16'h0008; wdata = 32'h12345678;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("rstw_rdy", {31'b0, rdy[1]}, 32'd0);
    check("rstw_rdata", rdat[1], 32'd0);
    check("rstw_err", {31'b0, errs[1]}, 32'd0);
    reset = 1'b1; v[1] = 1'b0; write = 1'b0;
    @(negedge clk);
    check("rstw_idle_rdy", {31'b0, rdy[1]}, 32'd0);
    run(1, 1'b1, 1'b0, 16'h0008, 32'd0, 1'b1, 32'd0, 1'b0, "rstw_rd08");
    run(1, 1'b1, 1'b0, 16'h0010, 32'd0, 1'b1, 32'd0, 1'b0, "rstw_rd10");

    // 6: zero wait states, back-to-back writes with valid held
    @(negedge clk);
    v[0] = 1'b1; write = 1'b1; addr = 16'h0000; wdata = 32'h11111111;
    @(negedge clk);
    check("b2b_rdy1", {31'b0, rdy[0]}, 32'd1);
    addr = 16'h0004; wdata = 32'h22222222;
    @(negedge clk);
    check("b2b_dead", {31'b0, rdy[0]}, 32'd0);
    @(negedge clk);
    check("b2b_rdy2", {31'b0, rdy[0]}, 32'd1);
    v[0] = 1'b0; write = 1'b0;
    @(negedge clk);
    check("b2b_drop", {31'b0, rdy[0]}, 32'd0);
    run(0, 1'b1, 1'b0, 16'h0000, 32'd0, 1'b1, 32'h11111111, 1'b0, "b2b_rd00");
    run(0, 1'b1, 1'b0, 16'h0004, 32'd0, 1'b1, 32'h22222222, 1'b0, "b2b_rd04");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
